// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: control-level
// encodings, the MUL/DIV occupancy state type, and a sizing helper.
package pipe_hazard_ctrl_pkg;

   // Active level of the synchronous reset input.
   localparam logic RST_ENABLED   = 1'b1;
   // Level of a pipeline register / PC enable that lets the register load.
   localparam logic WRITE_ENABLED = 1'b1;
   // Level of the ID/EXE bubble line that forces an all-zero load.
   localparam logic STOP          = 1'b1;

   // EXE occupancy state: free, or held by a multi-cycle MUL/DIV.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_t;

   // Width of the MUL/DIV occupancy counter: must hold the larger latency.
   function automatic int md_cnt_width(input int mul_cycles, input int div_cycles);
      int longest;
      longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// Loadable down-counter that tracks how many more cycles a MUL/DIV keeps
// EXE occupied. It only counts; the decision logic lives in the top level.
module pipe_md_timer
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         busy,
   output logic         last
);

   localparam logic [W-1:0] ONE = 1;

   logic [W-1:0] cnt;

   // Load takes priority; otherwise step toward zero and rest there.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLED) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
      end
   end

   assign busy = (cnt != '0);
   assign last = (cnt == ONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline. Inserts a single
// ID/EXE bubble on a load-use hazard and freezes the front end plus ID/EXE
// while a multi-cycle MUL/DIV sits in EXE. Counts stalled fetch cycles.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs_raddr,
   input  logic [4:0]       id_rt_raddr,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             id_mul_ena,
   input  logic             id_div_ena,
   input  logic [4:0]       exe_rf_waddr,
   input  logic             exe_rf_wena,
   input  logic             exe_load,
   output logic             pc_wena,
   output logic             if_id_wena,
   output logic             id_exe_wena,
   output logic             id_exe_stall,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int MD_W = md_cnt_width(MUL_CYCLES, DIV_CYCLES);

   // An N-cycle op is in EXE for the issue cycle plus N-1 frozen cycles.
   localparam logic [MD_W-1:0] MUL_LOAD  = MD_W'(MUL_CYCLES - 1);
   localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYCLES - 1);
   localparam logic            MUL_MULTI = (MUL_CYCLES > 1);
   localparam logic            DIV_MULTI = (DIV_CYCLES > 1);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   md_state_t       state;
   logic            load_use;
   logic            rs_hit;
   logic            rt_hit;
   logic            md_req;
   logic [MD_W-1:0] md_load_val;
   logic            md_issue;
   logic            md_timer_busy;
   logic            md_last;

   // Register 0 is hardwired to zero, so a load targeting it never hazards.
   always_comb begin
      rs_hit   = id_rs_used & (id_rs_raddr == exe_rf_waddr);
      rt_hit   = id_rt_used & (id_rt_raddr == exe_rf_waddr);
      load_use = exe_load & exe_rf_wena & (exe_rf_waddr != 5'd0) & (rs_hit | rt_hit);
   end

   // Pick the occupancy of the ID op; DIV wins when both flags are raised.
   always_comb begin
      if (id_div_ena) begin
         md_req      = DIV_MULTI;
         md_load_val = DIV_LOAD;
      end else begin
         md_req      = id_mul_ena & MUL_MULTI;
         md_load_val = MUL_LOAD;
      end
   end

   // A MUL/DIV that collides with a load-use bubble waits and retries.
   assign md_issue = (state == ST_IDLE) & ~load_use & md_req;

   pipe_md_timer #(
      .W (MD_W)
   ) u_md_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (md_issue),
      .value (md_load_val),
      .busy  (md_timer_busy),
      .last  (md_last)
   );

   // Occupancy FSM: enter on issue, leave when the timer reaches its last count.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLED) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (md_issue) begin
                  state <= ST_MD_BUSY;
               end
            end
            ST_MD_BUSY: begin
               if (md_last || !md_timer_busy) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Enable priority: reset, then MUL/DIV freeze, then load-use bubble, else run.
   always_comb begin
      pc_wena      = WRITE_ENABLED;
      if_id_wena   = WRITE_ENABLED;
      id_exe_wena  = WRITE_ENABLED;
      id_exe_stall = ~STOP;
      md_busy      = 1'b0;
      if (rst == RST_ENABLED) begin
         pc_wena      = ~WRITE_ENABLED;
         if_id_wena   = ~WRITE_ENABLED;
         id_exe_wena  = ~WRITE_ENABLED;
         id_exe_stall = STOP;
      end else if (state == ST_MD_BUSY) begin
         // ID/EXE must keep the MUL/DIV, so it is frozen rather than bubbled.
         pc_wena      = ~WRITE_ENABLED;
         if_id_wena   = ~WRITE_ENABLED;
         id_exe_wena  = ~WRITE_ENABLED;
         md_busy      = 1'b1;
      end else if (load_use) begin
         // One bubble suffices: the load moves on to MEM next cycle.
         pc_wena      = ~WRITE_ENABLED;
         if_id_wena   = ~WRITE_ENABLED;
         id_exe_stall = STOP;
      end
   end

   // Saturating count of cycles in which fetch was held.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLED) begin
         stall_cnt <= '0;
      end else if ((pc_wena != WRITE_ENABLED) && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Two instances share stimulus: a
// full-width one and one with a 4-bit stall counter to exercise saturation.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs_raddr, id_rt_raddr, exe_rf_waddr;
   logic        id_rs_used, id_rt_used, id_mul_ena, id_div_ena;
   logic        exe_rf_wena, exe_load;

   logic        pc_wena, if_id_wena, id_exe_wena, id_exe_stall, md_busy;
   logic [31:0] stall_cnt;
   logic        pc_wena_s, if_id_wena_s, id_exe_wena_s, id_exe_stall_s, md_busy_s;
   logic [3:0]  stall_cnt_s;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(33), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs_raddr(id_rs_raddr), .id_rt_raddr(id_rt_raddr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_mul_ena(id_mul_ena), .id_div_ena(id_div_ena),
      .exe_rf_waddr(exe_rf_waddr), .exe_rf_wena(exe_rf_wena), .exe_load(exe_load),
      .pc_wena(pc_wena), .if_id_wena(if_id_wena), .id_exe_wena(id_exe_wena),
      .id_exe_stall(id_exe_stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(33), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst),
      .id_rs_raddr(id_rs_raddr), .id_rt_raddr(id_rt_raddr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_mul_ena(id_mul_ena), .id_div_ena(id_div_ena),
      .exe_rf_waddr(exe_rf_waddr), .exe_rf_wena(exe_rf_wena), .exe_load(exe_load),
      .pc_wena(pc_wena_s), .if_id_wena(if_id_wena_s), .id_exe_wena(id_exe_wena_s),
      .id_exe_stall(id_exe_stall_s), .md_busy(md_busy_s), .stall_cnt(stall_cnt_s)
   );

   // Control vector order: {pc_wena, if_id_wena, id_exe_wena, id_exe_stall, md_busy}
   localparam logic [4:0] M_N = 5'b11100;  // normal flow
   localparam logic [4:0] M_B = 5'b00110;  // load-use bubble
   localparam logic [4:0] M_F = 5'b00001;  // MUL/DIV freeze
   localparam logic [4:0] M_R = 5'b00010;  // in reset

   typedef struct {
      logic [4:0]  ctl;
      logic [31:0] cnt;
      logic [3:0]  cnt_s;
      string       tag;
   } exp_t;

   exp_t        sbq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_cnt = 32'd0;
   bit          drive_done = 1'b0;

   task automatic check(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s/%s: got %0h want %0h at %0t", tag, fld, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and queue the hand-computed control response.
   task automatic step(input logic r, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic mul, input logic div,
                       input logic [4:0] wa, input logic we, input logic ld,
                       input logic [4:0] m, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_rs_raddr = rs; id_rs_used = rsu; id_rt_raddr = rt; id_rt_used = rtu;
      id_mul_ena = mul; id_div_ena = div;
      exe_rf_waddr = wa; exe_rf_wena = we; exe_load = ld;
      e.ctl   = m;
      e.cnt   = model_cnt;
      e.cnt_s = (model_cnt > 32'd15) ? 4'd15 : model_cnt[3:0];
      e.tag   = tag;
      sbq.push_back(e);
      if (r) model_cnt = 32'd0;
      else if (!m[4]) model_cnt = model_cnt + 32'd1;
   endtask

   task automatic idle(input logic [4:0] m, input string tag);
      step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, m, tag);
   endtask

   task automatic rst_cyc(input string tag);
      step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, M_R, tag);
   endtask

   // lw $8 in EXE, ID reads $8 through rs
   task automatic lu(input logic mul, input logic [4:0] m, input string tag);
      step(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, mul, 1'b0, 5'd8, 1'b1, 1'b1, m, tag);
   endtask

   task automatic md(input logic mul, input logic div, input logic [4:0] m, input string tag);
      step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, mul, div, 5'd0, 1'b0, 1'b0, m, tag);
   endtask

   // Monitor: compare the queued expectation against both instances each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, "ctl", {27'd0, pc_wena, if_id_wena, id_exe_wena, id_exe_stall, md_busy},
                  {27'd0, e.ctl});
            check(e.tag, "stall_cnt", stall_cnt, e.cnt);
            check(e.tag, "ctl_s", {27'd0, pc_wena_s, if_id_wena_s, id_exe_wena_s, id_exe_stall_s,
                  md_busy_s}, {27'd0, e.ctl});
            check(e.tag, "stall_cnt_s", {28'd0, stall_cnt_s}, {28'd0, e.cnt_s});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1; id_rs_raddr = 5'd0; id_rt_raddr = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
      id_mul_ena = 1'b0; id_div_ena = 1'b0; exe_rf_waddr = 5'd0; exe_rf_wena = 1'b0; exe_load = 1'b0;
      repeat (2) @(posedge clk);

      rst_cyc("reset_pre");
      rst_cyc("reset_pre");

      // reset while a DIV is in flight (md_cnt at 20)
      md(1'b0, 1'b1, M_N, "div_issue_a");
      for (int i = 0; i < 12; i++) idle(M_F, "div_busy_a");
      rst_cyc("reset_mid");
      rst_cyc("reset_mid");
      idle(M_N, "after_reset");
      idle(M_N, "after_reset");

      // load-use via rs, then via rt
      lu(1'b0, M_B, "lu_rs");
      idle(M_N, "lu_rs_resume");
      step(1'b0, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, M_B, "lu_rt");
      idle(M_N, "lu_rt_resume");

      // no hazard cases
      step(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, M_N, "lw_to_zero");
      step(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, M_N, "add_no_load");
      step(1'b0, 5'd8, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, M_N, "rs_unused");
      step(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, M_N, "no_wena");

      // DIV occupies EXE 33 cycles: 32 frozen, load-use ignored while frozen
      md(1'b0, 1'b1, M_N, "div_issue");
      for (int i = 0; i < 32; i++) begin
         if (i < 4) lu(1'b0, M_F, "div_busy_lu");
         else idle(M_F, "div_busy");
      end
      idle(M_N, "div_resume");

      // MUL deferred by load-use, then one frozen cycle
      lu(1'b1, M_B, "mul_lu_bubble");
      md(1'b1, 1'b0, M_N, "mul_issue");
      idle(M_F, "mul_busy");
      idle(M_N, "mul_resume");

      // back-to-back MUL
      md(1'b1, 1'b0, M_N, "b2b_issue1");
      md(1'b1, 1'b0, M_F, "b2b_busy1");
      md(1'b1, 1'b0, M_N, "b2b_issue2");
      idle(M_F, "b2b_busy2");
      idle(M_N, "b2b_resume");

      // MUL and DIV both flagged: DIV latency applies
      md(1'b1, 1'b1, M_N, "both_issue");
      for (int i = 0; i < 32; i++) idle(M_F, "both_busy");
      idle(M_N, "both_resume");

      // saturation of the 4-bit counter
      rst_cyc("reset_sat");
      rst_cyc("reset_sat");
      for (int i = 0; i < 20; i++) lu(1'b0, M_B, "sat_hold");
      idle(M_N, "sat_end");
      idle(M_N, "sat_end");

      drive_done = 1'b1;
      repeat (3) @(posedge clk);
      check("drain", "queue_left", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
